// File: rtl/hbwif_align_pkg.sv
// Shared types and constants for the hbwif receive word aligner.
package hbwif_align_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } align_state_e;

   localparam int DEF_WIDTH = 16;
   localparam int OFFSET_W  = $clog2(DEF_WIDTH);
   localparam logic [DEF_WIDTH-1:0] DEF_COMMA = 16'h5A3C;

endpackage

// File: rtl/hbwif_comma_finder.sv
// Parallel comma search over every bit offset of a two-word window.
// Candidate k starts k bits into the window (MSB = earliest bit); the
// lowest matching offset wins.
module hbwif_comma_finder
   import hbwif_align_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter logic [WIDTH-1:0] COMMA = DEF_COMMA
) (
   input  logic [2*WIDTH-1:0]         win,
   output logic [WIDTH-1:0]           match,
   output logic                       any_hit,
   output logic [$clog2(WIDTH)-1:0]   hit_idx
);

   localparam int OW = $clog2(WIDTH);

   for (genvar k = 0; k < WIDTH; k++) begin : g_cand
      assign match[k] = (win[2*WIDTH-1-k -: WIDTH] == COMMA);
   end

   assign any_hit = |match;

   // Priority encoder: scan from the top so the lowest hit is written last.
   always_comb begin
      hit_idx = '0;
      for (int k = WIDTH-1; k >= 0; k--) begin
         if (match[k]) hit_idx = OW'(k);
      end
   end

endmodule

// File: rtl/hbwif_rx_word_aligner.sv
// Receive word aligner: finds the comma boundary in the deserialized
// stream, locks after LOCK_COUNT consecutive hits at one offset and then
// emits aligned words one cycle after the window completes.
// Optional counter-pattern checker: define HBWIF_ALIGN_CHECK_EN.
//
//   state  | meaning
//   SEARCH | scanning all offsets for a comma
//   VERIFY | offset latched, counting consecutive commas at that offset
//   LOCKED | boundary fixed, aligned words flow out with io_data_valid
module hbwif_rx_word_aligner
   import hbwif_align_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter logic [WIDTH-1:0] COMMA = DEF_COMMA,
   parameter int LOCK_COUNT = 4,
   parameter int UNLOCK_COUNT = 4
) (
   input  logic                       io_clkd,
   input  logic                       io_reset_n,
   input  logic [WIDTH-1:0]           io_rx_in,
   input  logic                       io_realign,
   output logic [WIDTH-1:0]           io_data_out,
   output logic                       io_data_valid,
   output logic                       io_locked,
   output logic [$clog2(WIDTH)-1:0]   io_offset,
   output logic [15:0]                io_err_count
);

   localparam int OW = $clog2(WIDTH);

   align_state_e        state, state_nxt;
   logic [WIDTH-1:0]    prev;
   logic [2*WIDTH-1:0]  win;
   logic [WIDTH-1:0]    match;
   logic                any_hit;
   logic [OW-1:0]       hit_idx;
   logic [OW-1:0]       offset_nxt;
   logic [3:0]          hits_left, hits_left_nxt;
   logic [WIDTH-1:0]    cand;
   logic                sel_hit;
   logic                chk_drop;

   assign win = {prev, io_rx_in};

   hbwif_comma_finder #(
      .WIDTH (WIDTH),
      .COMMA (COMMA)
   ) u_finder (
      .win     (win),
      .match   (match),
      .any_hit (any_hit),
      .hit_idx (hit_idx)
   );

   assign sel_hit = match[io_offset];

   // Select the window slice at the latched offset.
   always_comb begin
      cand = '0;
      for (int k = 0; k < WIDTH; k++) begin
         if (io_offset == OW'(k)) cand = win[2*WIDTH-1-k -: WIDTH];
      end
   end

`ifdef HBWIF_ALIGN_CHECK_EN
   logic [WIDTH-1:0] exp_word;
   logic             seeded;
   logic [15:0]      err_cnt;
   logic [3:0]       miss_left;
   logic             chk_active;
   logic             chk_mismatch;

   // Only words that are actually emitted get checked.
   assign chk_active   = (state == LOCKED) && !io_realign;
   assign chk_mismatch = chk_active && seeded && (cand != exp_word);
   assign chk_drop     = chk_mismatch && (miss_left == 4'd1);

   // Counter-pattern checker; expected value always re-seeds from the received word.
   always_ff @(posedge io_clkd) begin
      if (!io_reset_n) begin
         exp_word  <= '0;
         seeded    <= 1'b0;
         err_cnt   <= '0;
         miss_left <= '0;
      end else if (chk_active) begin
         exp_word <= cand + WIDTH'(1);
         if (!seeded) begin
            seeded    <= 1'b1;
            miss_left <= 4'(UNLOCK_COUNT);
         end else if (chk_mismatch) begin
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            miss_left <= miss_left - 4'd1;
            if (chk_drop) seeded <= 1'b0;
         end else begin
            miss_left <= 4'(UNLOCK_COUNT);
         end
      end else begin
         seeded <= 1'b0;
      end
   end

   assign io_err_count = err_cnt;
`else
   assign chk_drop     = 1'b0;
   assign io_err_count = '0;
`endif

   // Next-state, hit countdown and offset capture.
   always_comb begin
      state_nxt     = state;
      hits_left_nxt = hits_left;
      offset_nxt    = io_offset;
      if (io_realign || chk_drop) begin
         state_nxt     = SEARCH;
         hits_left_nxt = '0;
      end else begin
         case (state)
            SEARCH: begin
               if (any_hit) begin
                  offset_nxt = hit_idx;
                  if (LOCK_COUNT <= 1) begin
                     state_nxt     = LOCKED;
                     hits_left_nxt = '0;
                  end else begin
                     state_nxt     = VERIFY;
                     hits_left_nxt = 4'(LOCK_COUNT - 1);
                  end
               end
            end
            VERIFY: begin
               if (sel_hit) begin
                  if (hits_left <= 4'd1) begin
                     state_nxt     = LOCKED;
                     hits_left_nxt = '0;
                  end else begin
                     hits_left_nxt = hits_left - 4'd1;
                  end
               end else begin
                  state_nxt     = SEARCH;
                  hits_left_nxt = '0;
               end
            end
            LOCKED: state_nxt = LOCKED;
            default: begin
               state_nxt     = SEARCH;
               hits_left_nxt = '0;
            end
         endcase
      end
   end

   // State register; io_locked tracks the state it is moving into.
   always_ff @(posedge io_clkd) begin
      if (!io_reset_n) begin
         state     <= SEARCH;
         hits_left <= '0;
         io_offset <= '0;
         io_locked <= 1'b0;
      end else begin
         state     <= state_nxt;
         hits_left <= hits_left_nxt;
         io_offset <= offset_nxt;
         io_locked <= (state_nxt == LOCKED);
      end
   end

   // Previous-word register and aligned output; data holds when not emitting.
   always_ff @(posedge io_clkd) begin
      if (!io_reset_n) begin
         prev          <= '0;
         io_data_out   <= '0;
         io_data_valid <= 1'b0;
      end else begin
         prev <= io_rx_in;
         if (state == LOCKED && state_nxt == LOCKED) begin
            io_data_out   <= cand;
            io_data_valid <= 1'b1;
         end else begin
            io_data_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_hbwif_rx_word_aligner.sv
// Self-checking bench for hbwif_rx_word_aligner. Builds a serial bit
// stream from transmitted words (with an optional bit shift), chops it
// into deserialized words and scoreboards the aligned output.
module tb_hbwif_rx_word_aligner;

   localparam logic [15:0] C = 16'h5A3C;

   logic        io_clkd = 1'b0;
   logic        io_reset_n = 1'b0;
   logic [15:0] io_rx_in = '0;
   logic        io_realign = 1'b0;
   logic [15:0] io_data_out;
   logic        io_data_valid;
   logic        io_locked;
   logic [3:0]  io_offset;
   logic [15:0] io_err_count;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] tx_words[$];
   logic [15:0] sb[$];
   int          err_exp[$];

   hbwif_rx_word_aligner #(
      .WIDTH        (16),
      .COMMA        (16'h5A3C),
      .LOCK_COUNT   (4),
      .UNLOCK_COUNT (4)
   ) dut (
      .io_clkd       (io_clkd),
      .io_reset_n    (io_reset_n),
      .io_rx_in      (io_rx_in),
      .io_realign    (io_realign),
      .io_data_out   (io_data_out),
      .io_data_valid (io_data_valid),
      .io_locked     (io_locked),
      .io_offset     (io_offset),
      .io_err_count  (io_err_count)
   );

   always #5 io_clkd = ~io_clkd;

   task automatic tick();
      @(posedge io_clkd);
      #1;
   endtask

   task automatic apply_reset();
      io_reset_n = 1'b0;
      io_realign = 1'b0;
      io_rx_in   = '0;
      tick();
      tick();
      io_reset_n = 1'b1;
   endtask

   function automatic bit lk(int n, int lock_idx, int drop_idx, int relock_idx);
      bit l;
      l = (n >= lock_idx);
      if (drop_idx >= 0 && n >= drop_idx) l = 1'b0;
      if (relock_idx >= 0 && n >= relock_idx) l = 1'b1;
      return l;
   endfunction

   // Drives tx_words shifted by s bits. Transmitted word j completes its
   // window on rx cycle j+1, so it is emitted after that edge when locked.
   task automatic run_stream(string name, int s, int lock_idx, int drop_idx,
                             bit pulse, int relock_idx);
      logic        bits[$];
      logic [15:0] rx;
      logic [15:0] exp_d;
      int          ncyc;
      bit          exp_l, exp_v;
      apply_reset();
      sb.delete();
      for (int i = 0; i < s; i++) bits.push_back(1'b0);
      foreach (tx_words[j]) begin
         for (int b = 15; b >= 0; b--) bits.push_back(tx_words[j][b]);
      end
      ncyc = tx_words.size() + 1;
      while (bits.size() < 16*ncyc) bits.push_back(1'b0);
      for (int n = 0; n < ncyc; n++) begin
         for (int b = 0; b < 16; b++) rx[15-b] = bits[16*n+b];
         io_rx_in   = rx;
         io_realign = pulse && (n == drop_idx);
         exp_l = lk(n, lock_idx, drop_idx, relock_idx);
         exp_v = (n > 0) && exp_l && lk(n-1, lock_idx, drop_idx, relock_idx);
         if (exp_v) sb.push_back(tx_words[n-1]);
         tick();
         io_realign = 1'b0;
         n_cmp++;
         if (io_locked !== exp_l) begin
            n_bad++;
            $display("FAIL %s locked cyc %0d: got %b want %b", name, n, io_locked, exp_l);
         end
         n_cmp++;
         if (io_data_valid !== exp_v) begin
            n_bad++;
            $display("FAIL %s valid cyc %0d: got %b want %b", name, n, io_data_valid, exp_v);
         end
         if (io_data_valid === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_bad++;
               $display("FAIL %s data cyc %0d: got %h want nothing", name, n, io_data_out);
            end else begin
               exp_d = sb.pop_front();
               if (io_data_out !== exp_d) begin
                  n_bad++;
                  $display("FAIL %s data cyc %0d: got %h want %h", name, n, io_data_out, exp_d);
               end
            end
         end
         if (err_exp.size() > n) begin
            n_cmp++;
            if (io_err_count !== 16'(err_exp[n])) begin
               n_bad++;
               $display("FAIL %s err_count cyc %0d: got %0d want %0d", name, n, io_err_count, err_exp[n]);
            end
         end
      end
      n_cmp++;
      if (io_offset !== 4'(s)) begin
         n_bad++;
         $display("FAIL %s offset: got %0d want %0d", name, io_offset, s);
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL %s drain: got %0d words pending want 0", name, sb.size());
      end
`ifndef HBWIF_ALIGN_CHECK_EN
      n_cmp++;
      if (io_err_count !== 16'd0) begin
         n_bad++;
         $display("FAIL %s err_count tie: got %0d want 0", name, io_err_count);
      end
`endif
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++;
      if (io_data_out !== 16'd0) begin n_bad++; $display("FAIL reset data_out: got %h want 0000", io_data_out); end
      n_cmp++;
      if (io_data_valid !== 1'b0) begin n_bad++; $display("FAIL reset valid: got %b want 0", io_data_valid); end
      n_cmp++;
      if (io_locked !== 1'b0) begin n_bad++; $display("FAIL reset locked: got %b want 0", io_locked); end
      n_cmp++;
      if (io_offset !== 4'd0) begin n_bad++; $display("FAIL reset offset: got %0d want 0", io_offset); end
      n_cmp++;
      if (io_err_count !== 16'd0) begin n_bad++; $display("FAIL reset err_count: got %0d want 0", io_err_count); end
   endtask

   task automatic test_aligned();
      tx_words = '{C, C, C, C, C, C, 16'd0, 16'd1, 16'd2};
      err_exp.delete();
      run_stream("aligned", 0, 4, -1, 1'b0, -1);
   endtask

   task automatic test_broken_verify();
      tx_words = '{C, C, 16'h0000, C, C, C, C, 16'd0, 16'd1, 16'd2};
      err_exp.delete();
      run_stream("broken_verify", 0, 7, -1, 1'b0, -1);
   endtask

   task automatic test_realign();
      tx_words = '{C, C, C, C, C, C, C, C, C, C, C, C};
      err_exp.delete();
      run_stream("realign", 0, 4, 6, 1'b1, 10);
   endtask

   task automatic test_shifted();
      tx_words = '{C, C, C, C, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
      err_exp.delete();
      run_stream("shifted", 5, 4, -1, 1'b0, -1);
   endtask

   // Runs straight after test_shifted: DUT is locked with a nonzero word held.
   task automatic test_reset_mid_verify();
      logic        bits[$];
      logic [15:0] rx;
      io_rx_in   = '0;
      io_realign = 1'b1;
      tick();
      io_realign = 1'b0;
      n_cmp++;
      if (io_locked !== 1'b0) begin n_bad++; $display("FAIL midrst realign locked: got %b want 0", io_locked); end
      for (int i = 0; i < 5; i++) bits.push_back(1'b0);
      for (int j = 0; j < 3; j++) begin
         for (int b = 15; b >= 0; b--) bits.push_back(C[b]);
      end
      for (int n = 0; n < 3; n++) begin
         for (int b = 0; b < 16; b++) rx[15-b] = bits[16*n+b];
         io_rx_in = rx;
         if (n == 2) io_reset_n = 1'b0;
         tick();
         if (n == 1) begin
            n_cmp++;
            if (io_offset !== 4'd5) begin n_bad++; $display("FAIL midrst verify offset: got %0d want 5", io_offset); end
            n_cmp++;
            if (io_locked !== 1'b0) begin n_bad++; $display("FAIL midrst verify locked: got %b want 0", io_locked); end
         end
      end
      io_reset_n = 1'b1;
      n_cmp++;
      if (io_data_out !== 16'd0) begin n_bad++; $display("FAIL midrst data_out: got %h want 0000", io_data_out); end
      n_cmp++;
      if (io_data_valid !== 1'b0) begin n_bad++; $display("FAIL midrst valid: got %b want 0", io_data_valid); end
      n_cmp++;
      if (io_locked !== 1'b0) begin n_bad++; $display("FAIL midrst locked: got %b want 0", io_locked); end
      n_cmp++;
      if (io_offset !== 4'd0) begin n_bad++; $display("FAIL midrst offset: got %0d want 0", io_offset); end
      n_cmp++;
      if (io_err_count !== 16'd0) begin n_bad++; $display("FAIL midrst err_count: got %0d want 0", io_err_count); end
      for (int i = 0; i < 6; i++) begin
         io_rx_in = C;
         tick();
         n_cmp++;
         if (io_locked !== (i >= 4)) begin
            n_bad++;
            $display("FAIL midrst relock cyc %0d: got %b want %b", i, io_locked, (i >= 4));
         end
      end
   endtask

`ifdef HBWIF_ALIGN_CHECK_EN
   task automatic test_check();
      tx_words = '{C, C, C, C, 16'd10, 16'd11, 16'd12, 16'd99, 16'd100,
                   16'd7, 16'd7, 16'd7, 16'd7};
      err_exp = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 3, 4, 5};
      run_stream("checker", 0, 4, 13, 1'b0, -1);
      err_exp.delete();
   endtask
`endif

   initial begin
      test_reset();
      test_aligned();
      test_broken_verify();
      test_realign();
      test_shifted();
      test_reset_mid_verify();
`ifdef HBWIF_ALIGN_CHECK_EN
      test_check();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
